hazard_response_unit: RTL and testbench
=======================================

HAZARD_RESPONSE_UNIT -- requirements
Module: hazard_response_unit

Interface
REQ-001 SHALL have parameter DW, default 10, meaning datapath/PC/instruction width.
REQ-002 SHALL have parameter STALL_LIMIT, default 4, meaning max consecutive stall cycles before error.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port hazard  in  1  stall request for the IF/ID register and ID/EX bubble request.
REQ-007 SHALL have port PC_hazard  in  1  PC hold request.
REQ-008 SHALL have ports A, B, C, D  in  1 each  {A,B} RS forward select, {C,D} RT forward select.
REQ-009 SHALL have ports E, F  in  1 each  LA (r0) forward select from EX and M.
REQ-010 SHALL have port instr_in  in  DW  fetched instruction.
REQ-011 SHALL have ports rs_reg, rt_reg, la_reg  in  DW  register-file read data.
REQ-012 SHALL have ports alu_result_EX, mem_result_M  in  DW  forwarding sources.
REQ-013 SHALL have port ctrl_ID  in  3  {reg_write_en, MemtoReg, mem_we} from decode.
REQ-014 SHALL have ports branch_taken  in  1, branch_target  in  DW  branch redirect.
REQ-015 SHALL have port PC  out  DW  program counter.
REQ-016 SHALL have port instr_IF  out  DW  IF/ID instruction register.
REQ-017 SHALL have port ctrl_EX  out  3  ID/EX control register.
REQ-018 SHALL have ports rs_val_EX, rt_val_EX, la_val_EX  out  DW  ID/EX operand registers.
REQ-019 SHALL have ports stall_count  out  8, deadlock_err  out  1, state  out  2.

Function
REQ-020 FSM states SHALL be RUN=0, STALL=1, FLUSH=2; state output SHALL reflect the current state.
REQ-021 The PC SHALL go to PC+1 (mod 2^DW) each cycle in RUN with PC_hazard=0 and branch_taken=0.
REQ-022 The PC SHALL hold while PC_hazard=1.
REQ-023 Effect on IF/ID: instr_IF SHALL hold while hazard=1 and otherwise load instr_in.
REQ-024 Effect on ID/EX: hazard=1 SHALL load ctrl_EX=3'b000 (bubble), while operand registers still load.
REQ-025 RS operand mux: {A,B}=11 SHALL select alu_result_EX, 10 SHALL select mem_result_M, and 00 or 01 SHALL select rs_reg.
REQ-026 RT operand mux: {C,D} SHALL use the identical encoding onto rt_reg.
REQ-027 LA operand mux: E=1 SHALL select alu_result_EX, else F=1 SHALL select mem_result_M, else la_reg; E SHALL have priority over F.
REQ-028 branch_taken=1 with hazard=0 SHALL load PC=branch_target, load instr_IF=0 (NOP flush), and enter FLUSH.
REQ-029 FLUSH SHALL last exactly one cycle, load ctrl_EX=000, then return to RUN.
REQ-030 In FLUSH, PC SHALL increment and instr_IF SHALL load instr_in.
REQ-031 Simultaneous hazard=1 and branch_taken=1: hazard SHALL win, branch_taken SHALL be ignored, and the state SHALL go to STALL.
REQ-032 Transitions: RUN to STALL on hazard=1; STALL to RUN on hazard=0; FLUSH to STALL on hazard=1.
REQ-033 stall_count SHALL increment once per cycle with hazard=1 and saturate at 255.
REQ-034 A consecutive-stall counter SHALL clear on any hazard=0 cycle; deadlock_err SHALL set when it exceeds STALL_LIMIT and stay set (sticky) until reset.
REQ-035 All outputs SHALL be registered, giving one-cycle latency from inputs to ID/EX and IF/ID outputs.

Reset
REQ-036 Asserting rst_n=0 SHALL immediately force PC=0, instr_IF=0, ctrl_EX=0, all operand registers=0, stall_count=0, deadlock_err=0, state=RUN.
REQ-037 Reset mid-stall or mid-flush SHALL abandon the operation; the first post-reset edge SHALL behave as RUN.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding, the forward-select encodings (FWD_REG=00, FWD_MEM=10, FWD_ALU=11), the bubble constant 3'b000, and DW.
REQ-039 One sub-module, fwd_mux3 (DW-wide 3:1 operand select), SHALL be instantiated three times for RS, RT and LA.

Verification
REQ-040 Bench SHALL cover free run: reset release, 3 cycles with no hazard -> PC=1,2,3, state=RUN.
REQ-041 Bench SHALL cover load-use stall: hazard=PC_hazard=1 for 1 cycle at PC=5 -> PC holds 5, instr_IF holds, ctrl_EX=000, stall_count=1, then PC=6.
REQ-042 Bench SHALL cover forwarding: {A,B}=11 with alu_result_EX=0x2AA -> rs_val_EX=0x2AA; {C,D}=10 with mem_result_M=0x155 -> rt_val_EX=0x155; E=F=1 -> la_val_EX=alu_result_EX.
REQ-043 Bench SHALL cover branch: branch_taken=1, target=0x3F0 -> PC=0x3F0, instr_IF=0, state=FLUSH for one cycle, ctrl_EX=000, then RUN with PC=0x3F1.
REQ-044 Bench SHALL cover conflict and wrap: hazard=1 with branch_taken=1 -> no redirect, state=STALL; PC=0x3FF free-running -> PC=0x000.
REQ-045 Bench SHALL cover deadlock: hazard held for 5 cycles -> deadlock_err=1 from the 5th cycle and still set after hazard drops; async rst_n pulse mid-stall -> all outputs zero at once.

Source files
------------

// File: rtl/hazard_response_unit_pkg.sv
// ============================================================================
// hazard_response_unit_pkg
// Shared FSM encoding, forward-select codes and bubble constant.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_response_unit_pkg;

    localparam int DW = 10;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hru_state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_ALU = 2'b11;

    localparam logic [2:0] CTRL_BUBBLE = 3'b000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_response_unit_fwd_mux3.sv
// ============================================================================
// fwd_mux3
// DW-wide operand select: ALU result, memory result or register-file data.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fwd_mux3 #(
    parameter int DW = 10
) (
    input  logic [1:0]    sel,
    input  logic [DW-1:0] reg_val,
    input  logic [DW-1:0] mem_val,
    input  logic [DW-1:0] alu_val,
    output logic [DW-1:0] out_val
);
    import hazard_response_unit_pkg::*;

    always_comb begin
        out_val = reg_val;
        case (sel)
            FWD_ALU: out_val = alu_val;
            FWD_MEM: out_val = mem_val;
            default: out_val = reg_val;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/hazard_response_unit.sv
// ============================================================================
// hazard_response_unit
// PC, IF/ID and ID/EX pipeline registers with stall, flush and forwarding.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_response_unit #(
    parameter int DW          = hazard_response_unit_pkg::DW,
    parameter int STALL_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hazard,
    input  logic          PC_hazard,
    input  logic          A,
    input  logic          B,
    input  logic          C,
    input  logic          D,
    input  logic          E,
    input  logic          F,
    input  logic [DW-1:0] instr_in,
    input  logic [DW-1:0] rs_reg,
    input  logic [DW-1:0] rt_reg,
    input  logic [DW-1:0] la_reg,
    input  logic [DW-1:0] alu_result_EX,
    input  logic [DW-1:0] mem_result_M,
    input  logic [2:0]    ctrl_ID,
    input  logic          branch_taken,
    input  logic [DW-1:0] branch_target,
    output logic [DW-1:0] PC,
    output logic [DW-1:0] instr_IF,
    output logic [2:0]    ctrl_EX,
    output logic [DW-1:0] rs_val_EX,
    output logic [DW-1:0] rt_val_EX,
    output logic [DW-1:0] la_val_EX,
    output logic [7:0]    stall_count,
    output logic          deadlock_err,
    output logic [1:0]    state
);
    import hazard_response_unit_pkg::*;

    hru_state_e    state_q, state_d;
    logic [DW-1:0] pc_q, pc_d, instr_q, instr_d;
    logic [DW-1:0] rs_q, rt_q, la_q, rs_d, rt_d, la_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic [7:0]    stall_cnt_q, stall_cnt_d, consec_q, consec_d;
    logic          err_q, err_d;
    logic [1:0]    la_sel;
    logic          redirect;

    // E outranks F, so fold the pair into the shared select encoding
    assign la_sel   = E ? FWD_ALU : (F ? FWD_MEM : FWD_REG);
    assign redirect = branch_taken && !hazard;

    fwd_mux3 #(.DW(DW)) u_fwd_rs (
        .sel(({A, B})), .reg_val(rs_reg), .mem_val(mem_result_M),
        .alu_val(alu_result_EX), .out_val(rs_d)
    );
    fwd_mux3 #(.DW(DW)) u_fwd_rt (
        .sel(({C, D})), .reg_val(rt_reg), .mem_val(mem_result_M),
        .alu_val(alu_result_EX), .out_val(rt_d)
    );
    fwd_mux3 #(.DW(DW)) u_fwd_la (
        .sel(la_sel), .reg_val(la_reg), .mem_val(mem_result_M),
        .alu_val(alu_result_EX), .out_val(la_d)
    );

    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        ctrl_d      = ctrl_ID;
        state_d     = ST_RUN;
        stall_cnt_d = stall_cnt_q;
        consec_d    = 8'd0;
        err_d       = err_q;

        if (!PC_hazard) begin
            pc_d = redirect ? branch_target : pc_q + DW'(1);
        end

        if (!hazard) begin
            instr_d = branch_taken ? '0 : instr_in;
        end

        if (hazard || state_q == ST_FLUSH) begin
            ctrl_d = CTRL_BUBBLE;
        end

        // Hazard wins over a simultaneous branch from any state
        if (hazard) begin
            state_d     = ST_STALL;
            stall_cnt_d = sat_inc8(stall_cnt_q);
            consec_d    = sat_inc8(consec_q);
        end else if (branch_taken) begin
            state_d = ST_FLUSH;
        end

        if (int'(consec_d) > STALL_LIMIT) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pc_q        <= '0;
            instr_q     <= '0;
            ctrl_q      <= CTRL_BUBBLE;
            rs_q        <= '0;
            rt_q        <= '0;
            la_q        <= '0;
            stall_cnt_q <= 8'd0;
            consec_q    <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            ctrl_q      <= ctrl_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            la_q        <= la_d;
            stall_cnt_q <= stall_cnt_d;
            consec_q    <= consec_d;
            err_q       <= err_d;
        end
    end

    assign PC           = pc_q;
    assign instr_IF     = instr_q;
    assign ctrl_EX      = ctrl_q;
    assign rs_val_EX    = rs_q;
    assign rt_val_EX    = rt_q;
    assign la_val_EX    = la_q;
    assign stall_count  = stall_cnt_q;
    assign deadlock_err = err_q;
    assign state        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_response_unit.sv
// ============================================================================
// tb_hazard_response_unit
// Directed and random checks of hazard_response_unit against a reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_response_unit;
    localparam int DW  = 10;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic hazard, PC_hazard, A, B, C, D, E, F, branch_taken;
    logic [DW-1:0] instr_in, rs_reg, rt_reg, la_reg, alu_result_EX, mem_result_M, branch_target;
    logic [2:0]    ctrl_ID;
    logic [DW-1:0] PC, instr_IF, rs_val_EX, rt_val_EX, la_val_EX;
    logic [2:0]    ctrl_EX;
    logic [7:0]    stall_count;
    logic          deadlock_err;
    logic [1:0]    state;

    always #5 clk = ~clk;

    hazard_response_unit #(.DW(DW), .STALL_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n), .hazard(hazard), .PC_hazard(PC_hazard),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F),
        .instr_in(instr_in), .rs_reg(rs_reg), .rt_reg(rt_reg), .la_reg(la_reg),
        .alu_result_EX(alu_result_EX), .mem_result_M(mem_result_M),
        .ctrl_ID(ctrl_ID), .branch_taken(branch_taken), .branch_target(branch_target),
        .PC(PC), .instr_IF(instr_IF), .ctrl_EX(ctrl_EX),
        .rs_val_EX(rs_val_EX), .rt_val_EX(rt_val_EX), .la_val_EX(la_val_EX),
        .stall_count(stall_count), .deadlock_err(deadlock_err), .state(state)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: pipeline contents as plain integers; state 0=RUN 1=STALL 2=FLUSH
    int m_pc, m_instr, m_ctrl, m_rs, m_rt, m_la, m_stall, m_consec, m_err, m_st;

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_la = 0;
        m_stall = 0; m_consec = 0; m_err = 0; m_st = 0;
    endtask

    function automatic int pick2(input logic [1:0] sel, input int r);
        if (sel == 2'b11) return int'(alu_result_EX);
        if (sel == 2'b10) return int'(mem_result_M);
        return r;
    endfunction

    task automatic model_step();
        int nxt_pc;
        nxt_pc = m_pc;
        if (!PC_hazard)
            nxt_pc = (branch_taken && !hazard) ? int'(branch_target) : (m_pc + 1) % (1 << DW);
        if (!hazard) m_instr = branch_taken ? 0 : int'(instr_in);
        m_ctrl = (hazard || m_st == 2) ? 0 : int'(ctrl_ID);
        m_rs = pick2({A, B}, int'(rs_reg));
        m_rt = pick2({C, D}, int'(rt_reg));
        m_la = E ? int'(alu_result_EX) : (F ? int'(mem_result_M) : int'(la_reg));
        m_st = hazard ? 1 : (branch_taken ? 2 : 0);
        if (hazard) begin
            m_stall  = (m_stall < 255) ? m_stall + 1 : 255;
            m_consec = m_consec + 1;
        end else begin
            m_consec = 0;
        end
        if (m_consec > LIM) m_err = 1;
        m_pc = nxt_pc;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("PC",           32'(PC),           32'(m_pc));
        check("instr_IF",     32'(instr_IF),     32'(m_instr));
        check("ctrl_EX",      32'(ctrl_EX),      32'(m_ctrl));
        check("rs_val_EX",    32'(rs_val_EX),    32'(m_rs));
        check("rt_val_EX",    32'(rt_val_EX),    32'(m_rt));
        check("la_val_EX",    32'(la_val_EX),    32'(m_la));
        check("stall_count",  32'(stall_count),  32'(m_stall));
        check("deadlock_err", 32'(deadlock_err), 32'(m_err));
        check("state",        32'(state),        32'(m_st));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        hazard = 0; PC_hazard = 0; branch_taken = 0; branch_target = '0;
        {A, B, C, D, E, F} = 6'b0;
        instr_in = DW'($urandom); rs_reg = DW'($urandom); rt_reg = DW'($urandom);
        la_reg = DW'($urandom); alu_result_EX = DW'($urandom); mem_result_M = DW'($urandom);
        ctrl_ID = 3'($urandom);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // free run
        for (int i = 1; i <= 3; i++) begin
            idle(); tick();
            check("free_pc", 32'(PC), 32'(i));
            check("free_state", 32'(state), 32'd0);
        end
        idle(); tick(); idle(); tick();
        check("pc_at_5", 32'(PC), 32'd5);

        // load-use stall
        idle(); hazard = 1; PC_hazard = 1; tick();
        check("stall_pc_hold", 32'(PC), 32'd5);
        check("stall_bubble", 32'(ctrl_EX), 32'd0);
        check("stall_count1", 32'(stall_count), 32'd1);
        idle(); tick();
        check("after_stall_pc", 32'(PC), 32'd6);

        // forwarding
        idle(); {A, B} = 2'b11; alu_result_EX = 10'h2AA; {C, D} = 2'b10;
        mem_result_M = 10'h155; E = 1; F = 1; tick();
        check("fwd_rs_alu", 32'(rs_val_EX), 32'h2AA);
        check("fwd_rt_mem", 32'(rt_val_EX), 32'h155);
        check("fwd_la_prio", 32'(la_val_EX), 32'h2AA);

        // branch and flush
        idle(); ctrl_ID = 3'b101; branch_taken = 1; branch_target = 10'h3F0; tick();
        check("br_pc", 32'(PC), 32'h3F0);
        check("br_instr_nop", 32'(instr_IF), 32'd0);
        check("br_flush", 32'(state), 32'd2);
        idle(); ctrl_ID = 3'b111; tick();
        check("flush_bubble", 32'(ctrl_EX), 32'd0);
        check("flush_run", 32'(state), 32'd0);
        check("flush_pc", 32'(PC), 32'h3F1);

        // hazard beats branch
        idle(); hazard = 1; branch_taken = 1; branch_target = 10'h100; tick();
        check("conflict_pc", 32'(PC), 32'h3F2);
        check("conflict_state", 32'(state), 32'd1);

        // wrap
        idle(); branch_taken = 1; branch_target = 10'h3FF; tick();
        idle(); tick();
        check("wrap_pc", 32'(PC), 32'h000);

        // deadlock
        for (int i = 1; i <= 5; i++) begin
            idle(); hazard = 1; PC_hazard = 1; tick();
            if (i == 4) check("dl_not_yet", 32'(deadlock_err), 32'd0);
        end
        check("dl_set", 32'(deadlock_err), 32'd1);
        idle(); tick();
        check("dl_sticky", 32'(deadlock_err), 32'd1);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            idle();
            hazard = ($urandom_range(0, 3) == 0);
            PC_hazard = hazard;
            branch_taken = ($urandom_range(0, 6) == 0);
            branch_target = DW'($urandom);
            {A, B, C, D, E, F} = 6'($urandom);
            tick();
        end

        // saturation of stall_count
        for (int i = 0; i < 260; i++) begin
            idle(); hazard = 1; PC_hazard = $urandom_range(0, 1) == 1; tick();
        end
        check("stall_sat", 32'(stall_count), 32'd255);

        // async reset mid-stall
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("rst_pc", 32'(PC), 32'd0);
        check("rst_err", 32'(deadlock_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(); tick();
        check("post_rst_pc", 32'(PC), 32'd1);
        check("post_rst_state", 32'(state), 32'd0);

        // async reset mid-flush
        idle(); branch_taken = 1; branch_target = 10'h0AB; tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(); ctrl_ID = 3'b110; tick();
        check("post_flush_rst_ctrl", 32'(ctrl_EX), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
